// File: rtl/hash_macro_port_pkg.sv
// Shared definitions for the hash macro port.
// Address map constants, work image sizing and the FSM state encoding
// used by hash_macro_port and hash_work_regfile.
package decred_defines;

  localparam logic [5:0] ADDR_RESULT0    = 6'h00;
  localparam logic [5:0] ADDR_STATUS     = 6'h04;
  localparam logic [5:0] ADDR_ID         = 6'h05;
  localparam logic [5:0] ADDR_WORK_BASE  = 6'h08;
  localparam logic [5:0] ADDR_NONCE_BASE = 6'h38;
  localparam logic [5:0] ADDR_IMAGE_END  = 6'h3B;

  localparam int WORK_BYTES  = 48;
  // Work bytes followed by the four start-nonce bytes, contiguous in the map.
  localparam int IMAGE_BYTES = WORK_BYTES + 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/hash_macro_port_work_regfile.sv
// hash_work_regfile: byte-writable storage for the work image (0x08-0x37)
// and the start nonce (0x38-0x3B). A byte is captured only on the rising
// edge of the write select, so a select held high writes exactly once.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   wr_sel          - write select level from the host
//   wr_addr/wr_data - byte address and data
//   work            - 384-bit work image, byte 0x08 in bits [7:0]
//   start_nonce     - little-endian start nonce
module hash_work_regfile
  import decred_defines::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_sel,
  input  logic [5:0]   wr_addr,
  input  logic [7:0]   wr_data,
  output logic [383:0] work,
  output logic [31:0]  start_nonce
);

  logic [IMAGE_BYTES*8-1:0] image;
  logic                     wr_sel_q;
  logic                     wr_pulse;

  assign wr_pulse = wr_sel && !wr_sel_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image    <= '0;
      wr_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel;
      if (wr_pulse) begin
        // Addresses outside 0x08-0x3B match no byte and are dropped.
        for (int i = 0; i < IMAGE_BYTES; i++) begin
          if (wr_addr == ADDR_WORK_BASE + 6'(i)) begin
            image[i*8 +: 8] <= wr_data;
          end
        end
      end
    end
  end

  assign work        = image[WORK_BYTES*8-1:0];
  assign start_nonce = image[IMAGE_BYTES*8-1:WORK_BYTES*8];

endmodule

// File: rtl/hash_macro_port.sv
// hash_macro_port: macro-side responder for the host register interface.
// Holds the host-written work image, walks nonces through one hash core
// and latches the first matching nonce.
// Optional macro HASH_MACRO_READBACK_EN: when defined, reads of 0x08-0x3B
// return the stored work/start-nonce bytes; otherwise they read 0.
// Ports:
//   CLK, RSTN                 - macro clock, asynchronous active-low reset
//   HASH_EN                   - run enable (already synchronised)
//   MACRO_WR_SELECT, DATA_TO_HASH, HASH_ADDR - host byte write
//   MACRO_RD_SELECT, DATA_FROM_HASH          - host byte read, 1-cycle latency
//   DATA_AVAILABLE            - match latched
//   CORE_WORK, CORE_NONCE     - operands for the hash core
//   CORE_START / CORE_DONE, CORE_MATCH       - core handshake
// Core handshake: CORE_START pulses for one cycle with CORE_NONCE stable;
// the core later pulses CORE_DONE for one cycle with CORE_MATCH valid in
// that same cycle. Only one hash is ever outstanding; CORE_DONE seen while
// no hash is outstanding is ignored.
module hash_macro_port
  import decred_defines::*;
#(
  parameter int unsigned NONCE_STEP = 1,
  parameter int unsigned THREAD_ID  = 0
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         HASH_EN,
  input  logic         MACRO_WR_SELECT,
  input  logic [7:0]   DATA_TO_HASH,
  input  logic         MACRO_RD_SELECT,
  input  logic [5:0]   HASH_ADDR,
  output logic         DATA_AVAILABLE,
  output logic [7:0]   DATA_FROM_HASH,
  output logic [383:0] CORE_WORK,
  output logic [31:0]  CORE_NONCE,
  output logic         CORE_START,
  input  logic         CORE_DONE,
  input  logic         CORE_MATCH
);

  fsm_state_t  state_q, state_n;
  logic [31:0] nonce_q, nonce_n;
  logic [31:0] result_q, result_n;
  logic        wrapped_q, wrapped_n;
  logic        avail_q, avail_n;
  logic [31:0] start_nonce;
  logic [32:0] nonce_sum;
  logic [7:0]  status;
  logic [7:0]  rd_byte;
  logic [7:0]  rd_data_q;

  hash_work_regfile u_regfile (
    .clk         (CLK),
    .rst_n       (RSTN),
    .wr_sel      (MACRO_WR_SELECT),
    .wr_addr     (HASH_ADDR),
    .wr_data     (DATA_TO_HASH),
    .work        (CORE_WORK),
    .start_nonce (start_nonce)
  );

  // Carry out of bit 32 marks a wrap of the nonce space.
  assign nonce_sum = {1'b0, nonce_q} + 33'(NONCE_STEP);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= IDLE;
      nonce_q   <= '0;
      result_q  <= '0;
      wrapped_q <= 1'b0;
      avail_q   <= 1'b0;
    end else begin
      state_q   <= state_n;
      nonce_q   <= nonce_n;
      result_q  <= result_n;
      wrapped_q <= wrapped_n;
      avail_q   <= avail_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    nonce_n   = nonce_q;
    result_n  = result_q;
    wrapped_n = wrapped_q;
    avail_n   = avail_q;
    case (state_q)
      IDLE: begin
        avail_n = 1'b0;
        if (HASH_EN) begin
          nonce_n   = start_nonce + THREAD_ID;
          wrapped_n = 1'b0;
          state_n   = ISSUE;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        // Disable is honoured only once the core has finished its hash.
        if (CORE_DONE) begin
          if (!HASH_EN) begin
            state_n = IDLE;
          end else if (CORE_MATCH) begin
            result_n = nonce_q;
            avail_n  = 1'b1;
            state_n  = HOLD;
          end else begin
            nonce_n = nonce_sum[31:0];
            if (nonce_sum[32]) wrapped_n = 1'b1;
            state_n = ISSUE;
          end
        end
      end
      HOLD: begin
        if (!HASH_EN) begin
          avail_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign CORE_START     = (state_q == ISSUE);
  assign CORE_NONCE     = nonce_q;
  assign DATA_AVAILABLE = avail_q;

  assign status = {5'b0, wrapped_q, (state_q != IDLE), avail_q};

  always_comb begin
    rd_byte = 8'h00;
    case (HASH_ADDR)
      ADDR_RESULT0:         rd_byte = result_q[7:0];
      ADDR_RESULT0 + 6'd1:  rd_byte = result_q[15:8];
      ADDR_RESULT0 + 6'd2:  rd_byte = result_q[23:16];
      ADDR_RESULT0 + 6'd3:  rd_byte = result_q[31:24];
      ADDR_STATUS:          rd_byte = status;
      ADDR_ID:              rd_byte = 8'(THREAD_ID);
      default: begin
`ifdef HASH_MACRO_READBACK_EN
        if (HASH_ADDR >= ADDR_WORK_BASE && HASH_ADDR <= ADDR_IMAGE_END) begin
          for (int i = 0; i < WORK_BYTES; i++) begin
            if (HASH_ADDR == ADDR_WORK_BASE + 6'(i)) rd_byte = CORE_WORK[i*8 +: 8];
          end
          for (int j = 0; j < 4; j++) begin
            if (HASH_ADDR == ADDR_NONCE_BASE + 6'(j)) rd_byte = start_nonce[j*8 +: 8];
          end
        end
`else
        rd_byte = 8'h00;
`endif
      end
    endcase
  end

  // Deselected macros drive 0 so several can be OR-combined on the bus.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= MACRO_RD_SELECT ? rd_byte : 8'h00;
    end
  end

  assign DATA_FROM_HASH = rd_data_q;

endmodule

// File: tb/tb_hash_macro_port.sv
// Directed bench for hash_macro_port (NONCE_STEP=4, THREAD_ID=2).
module tb_hash_macro_port;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic         HASH_EN;
  logic         MACRO_WR_SELECT;
  logic [7:0]   DATA_TO_HASH;
  logic         MACRO_RD_SELECT;
  logic [5:0]   HASH_ADDR;
  logic         DATA_AVAILABLE;
  logic [7:0]   DATA_FROM_HASH;
  logic [383:0] CORE_WORK;
  logic [31:0]  CORE_NONCE;
  logic         CORE_START;
  logic         CORE_DONE;
  logic         CORE_MATCH;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  hash_macro_port #(.NONCE_STEP(4), .THREAD_ID(2)) dut (
    .CLK             (CLK),
    .RSTN            (RSTN),
    .HASH_EN         (HASH_EN),
    .MACRO_WR_SELECT (MACRO_WR_SELECT),
    .DATA_TO_HASH    (DATA_TO_HASH),
    .MACRO_RD_SELECT (MACRO_RD_SELECT),
    .HASH_ADDR       (HASH_ADDR),
    .DATA_AVAILABLE  (DATA_AVAILABLE),
    .DATA_FROM_HASH  (DATA_FROM_HASH),
    .CORE_WORK       (CORE_WORK),
    .CORE_NONCE      (CORE_NONCE),
    .CORE_START      (CORE_START),
    .CORE_DONE       (CORE_DONE),
    .CORE_MATCH      (CORE_MATCH)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic host_write(input logic [5:0] a, input logic [7:0] d);
    HASH_ADDR       = a;
    DATA_TO_HASH    = d;
    MACRO_WR_SELECT = 1'b1;
    tick();
    MACRO_WR_SELECT = 1'b0;
    tick();
  endtask

  task automatic host_read(input logic [5:0] a, output logic [7:0] d);
    HASH_ADDR       = a;
    MACRO_RD_SELECT = 1'b1;
    tick();
    d               = DATA_FROM_HASH;
    MACRO_RD_SELECT = 1'b0;
  endtask

  task automatic wait_start(output logic [31:0] n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (CORE_START) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("start_seen", {31'b0, seen}, 32'd1);
    n = CORE_NONCE;
  endtask

  task automatic core_done(input logic m);
    tick();
    CORE_DONE  = 1'b1;
    CORE_MATCH = m;
    tick();
    CORE_DONE  = 1'b0;
    CORE_MATCH = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] n;
    logic [7:0]  rd;

    RSTN = 1'b0; HASH_EN = 1'b0; MACRO_WR_SELECT = 1'b0; DATA_TO_HASH = '0;
    MACRO_RD_SELECT = 1'b0; HASH_ADDR = '0; CORE_DONE = 1'b0; CORE_MATCH = 1'b0;
    #12;
    check("reset_start", {31'b0, CORE_START}, 32'd0);
    check("reset_avail", {31'b0, DATA_AVAILABLE}, 32'd0);
    check("reset_nonce", CORE_NONCE, 32'd0);
    check("reset_rdata", {24'b0, DATA_FROM_HASH}, 32'd0);
    check("reset_work_zero", {31'b0, (CORE_WORK == '0)}, 32'd1);
    RSTN = 1'b1;
    tick();

    // Byte writes at both ends of the work image.
    host_write(6'h08, 8'hA5);
    check("work_byte08", {24'b0, CORE_WORK[7:0]}, 32'h0000_00A5);
    host_write(6'h37, 8'h5A);
    check("work_byte37", {24'b0, CORE_WORK[383:376]}, 32'h0000_005A);

    // Select held high with changing data writes only once.
    HASH_ADDR = 6'h08; DATA_TO_HASH = 8'hA5; MACRO_WR_SELECT = 1'b1;
    tick();
    DATA_TO_HASH = 8'h11;
    repeat (10) tick();
    MACRO_WR_SELECT = 1'b0;
    tick();
    check("hold_select", {24'b0, CORE_WORK[7:0]}, 32'h0000_00A5);
    check("hold_neighbour", {24'b0, CORE_WORK[15:8]}, 32'h0);

    // Match search: start 0x10 + THREAD_ID 2, step 4, match on third done.
    host_write(6'h38, 8'h10);
    HASH_EN = 1'b1;
    wait_start(n);
    check("nonce_1", n, 32'h12);
    tick();
    check("start_one_cycle", {31'b0, CORE_START}, 32'd0);
    core_done(1'b0);
    wait_start(n);
    check("nonce_2", n, 32'h16);
    core_done(1'b0);
    wait_start(n);
    check("nonce_3", n, 32'h1A);
    core_done(1'b1);
    check("match_avail", {31'b0, DATA_AVAILABLE}, 32'd1);
    repeat (3) tick();
    check("hold_no_start", {31'b0, CORE_START}, 32'd0);
    host_read(6'h00, rd); check("result_b0", {24'b0, rd}, 32'h1A);
    host_read(6'h01, rd); check("result_b1", {24'b0, rd}, 32'h00);
    host_read(6'h02, rd); check("result_b2", {24'b0, rd}, 32'h00);
    host_read(6'h03, rd); check("result_b3", {24'b0, rd}, 32'h00);
    host_read(6'h04, rd); check("status_hold", {24'b0, rd}, 32'h03);

    // Clear by dropping the enable.
    HASH_EN = 1'b0;
    tick();
    check("clear_avail", {31'b0, DATA_AVAILABLE}, 32'd0);
    host_read(6'h04, rd); check("status_idle", {24'b0, rd}, 32'h00);

    // Wrap: start 0xFFFFFFFC + 2 = 0xFFFFFFFE, +4 wraps to 0x2.
    host_write(6'h38, 8'hFC);
    host_write(6'h39, 8'hFF);
    host_write(6'h3A, 8'hFF);
    host_write(6'h3B, 8'hFF);
    HASH_EN = 1'b1;
    wait_start(n);
    check("wrap_first", n, 32'hFFFF_FFFE);
    core_done(1'b0);
    wait_start(n);
    check("wrap_next", n, 32'h0000_0002);
    host_read(6'h04, rd); check("status_wrapped", {24'b0, rd}, 32'h06);
    core_done(1'b0);
    wait_start(n);
    check("wrap_after", n, 32'h0000_0006);
    HASH_EN = 1'b0;
    core_done(1'b0);
    tick();
    host_read(6'h04, rd); check("status_wrap_sticky", {24'b0, rd}, 32'h04);
    HASH_EN = 1'b1;
    wait_start(n);
    check("restart_nonce", n, 32'hFFFF_FFFE);
    host_read(6'h04, rd); check("status_wrap_cleared", {24'b0, rd}, 32'h02);

    // Disable mid-hash, then a matching done must be discarded.
    HASH_EN = 1'b0;
    core_done(1'b1);
    check("discard_avail", {31'b0, DATA_AVAILABLE}, 32'd0);
    host_read(6'h04, rd); check("discard_status", {24'b0, rd}, 32'h00);
    host_read(6'h00, rd); check("discard_result", {24'b0, rd}, 32'h1A);

    // Read select gating across the whole map.
    MACRO_RD_SELECT = 1'b0;
    for (int a = 0; a < 64; a++) begin
      HASH_ADDR = 6'(a);
      tick();
      check("rd_gated", {24'b0, DATA_FROM_HASH}, 32'h0);
    end

    host_read(6'h05, rd); check("thread_id", {24'b0, rd}, 32'h02);
    host_read(6'h06, rd); check("unmapped_06", {24'b0, rd}, 32'h00);
    host_read(6'h3C, rd); check("unmapped_3c", {24'b0, rd}, 32'h00);
`ifdef HASH_MACRO_READBACK_EN
    host_read(6'h38, rd); check("readback_38", {24'b0, rd}, 32'hFC);
    host_read(6'h08, rd); check("readback_08", {24'b0, rd}, 32'hA5);
    host_read(6'h37, rd); check("readback_37", {24'b0, rd}, 32'h5A);
`else
    host_read(6'h38, rd); check("readback_38", {24'b0, rd}, 32'h00);
    host_read(6'h08, rd); check("readback_08", {24'b0, rd}, 32'h00);
    host_read(6'h37, rd); check("readback_37", {24'b0, rd}, 32'h00);
`endif

    // Asynchronous reset while waiting on the core.
    HASH_EN = 1'b1;
    wait_start(n);
    HASH_ADDR = 6'h05;
    MACRO_RD_SELECT = 1'b1;
    tick();
    check("pre_reset_rdata", {24'b0, DATA_FROM_HASH}, 32'h02);
    #2;
    RSTN = 1'b0;
    #1;
    check("areset_nonce", CORE_NONCE, 32'd0);
    check("areset_start", {31'b0, CORE_START}, 32'd0);
    check("areset_avail", {31'b0, DATA_AVAILABLE}, 32'd0);
    check("areset_rdata", {24'b0, DATA_FROM_HASH}, 32'd0);
    check("areset_work_zero", {31'b0, (CORE_WORK == '0)}, 32'd1);
    MACRO_RD_SELECT = 1'b0;
    HASH_EN = 1'b0;
    #2;
    RSTN = 1'b1;
    tick();
    host_read(6'h04, rd); check("post_reset_status", {24'b0, rd}, 32'h00);
    host_read(6'h00, rd); check("post_reset_result", {24'b0, rd}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed run still active expected finish");
    $fatal(1, "timeout");
  end

endmodule
